buffer_pool_seq: RTL
====================

Name: buffer_pool_seq

Overview:
- Sequencer for the X_MESH×X_MAC dual-port bank array.
- LOAD command: streams scalar words from an upstream producer into the banks round-robin. Word i goes to bank (i mod BUFFER_NUM), row base+(i div BUFFER_NUM).
- READ command: sweeps a row range on port B of all banks in lockstep. Emits a valid strobe aligned with the array's 1-cycle read latency.
- Sits between the DMA/unpacker and the MAC mesh; drives the array's addra/dina/wea/addrb directly.

Parameters:
- X_MAC, 4, kernels per mesh port
- X_MESH, 16, mesh ports
- ADDR_LEN, 13, row address bits per bank
- DATA_LEN, 32, bits per word
- BANK_W, 6, log2(X_MAC*X_MESH); must equal it exactly
- BUFFER_NUM, X_MAC*X_MESH, bank count
- LEN_W, ADDR_LEN+BANK_W, load length width in words

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  1  0=LOAD, 1=READ
- cmd_base  in  ADDR_LEN  starting row
- cmd_len  in  LEN_W  LOAD: word count; READ: row count (low ADDR_LEN+1 bits used)
- in_data  in  DATA_LEN  load stream word
- in_valid  in  1  load word present
- in_ready  out  1  high only in LOAD
- dina  out  BUFFER_NUM*DATA_LEN  in_data replicated to every bank slice
- addra  out  BUFFER_NUM*ADDR_LEN  write row replicated to every bank slice
- wea  out  BUFFER_NUM  one-hot write enable; bank b at bit b = kernel+port*X_MAC
- addrb  out  BUFFER_NUM*ADDR_LEN  read row replicated to every bank slice
- rd_valid  out  1  doutb of the array valid this cycle
- rd_last  out  1  with rd_valid on the final row
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at command completion

Behaviour:
- Reset values: state=IDLE, cmd_ready=1, in_ready=0, wea=0, addra=0, addrb=0, rd_valid=0, rd_last=0, busy=0, done=0, all counters 0.
- A reset asserted mid-command aborts it immediately: no done pulse, wea=0 from the next edge on, and no further writes.
- Handshakes:
  - Command accepted on cmd_valid&cmd_ready.
  - Load word accepted on in_valid&in_ready; producer may hold in_valid with in_ready low.
- FSM states IDLE, LOAD, READ, DRAIN.
- IDLE:
  - On accept with cmd_len==0: stay in IDLE and pulse done next cycle; no wea or rd_valid activity.
  - Otherwise latch base/len, clear bank_cnt/row_cnt/word_cnt, and go to LOAD or READ per cmd_op.
- LOAD:
  - Outputs combinational from registers plus in_valid: wea = in_valid ? (1<<bank_cnt) : 0; dina = in_data (in all slices); addra = base+row_cnt mod 2^ADDR_LEN (in all slices).
  - Each accepted word: word_cnt++; bank_cnt++; when bank_cnt wraps BUFFER_NUM-1→0, row_cnt++.
  - Accepting word number len-1 moves the FSM to IDLE. done=1 in the following cycle; in_ready=0 from that cycle.
  - A gap cycle (in_valid=0) writes nothing and changes no counters.
- READ:
  - addrb registered = base+row_cnt mod 2^ADDR_LEN; one row per cycle, no backpressure.
  - rd_valid is a 1-cycle delayed copy of "address issued". rd_valid therefore rises the cycle after the first addrb, matching the array's registered read port.
  - After issuing row len-1, go to DRAIN.
- DRAIN: one cycle. rd_valid=1 and rd_last=1 for the final row; done=1 the same cycle; next state IDLE.
- Row address wrap: base+offset wraps modulo 2^ADDR_LEN silently (e.g. base=8190, 4 rows → 8190, 8191, 0, 1).
- The bank array's ports are independent, so no read/write hazard logic: only one command runs at a time.
- cmd_ready=0 in every state except IDLE; commands presented while busy are held by the master, not dropped.

Test Plan:
- Reset then LOAD base=0 len=130, in_valid constant 1 → in_ready high exactly 130 cycles. Word 0 goes to bank0 row0, word 63 to bank63 row0, word 64 to bank0 row1, word 129 to bank1 row2. done pulses once, the cycle after the last write.
- LOAD len=5 with in_valid toggling 1,0,1,0,… → exactly 5 writes, to banks 0–4 row base; wea=0 on gap cycles; done follows the 5th write.
- READ base=8190 len=4 → addrb 8190, 8191, 0, 1 on consecutive cycles. rd_valid high the 4 cycles starting one cycle after the first addrb; rd_last and done only on the 4th.
- cmd_len=0 for both LOAD and READ → done pulse one cycle later; wea, rd_valid and in_ready stay 0; busy stays 0.
- Assert rst during LOAD after 10 words, then issue READ len=1 → no done for the aborted load; cmd_ready=1 the cycle after rst falls; the READ completes normally.
- Present a new cmd_valid while READ busy → cmd_ready=0 until IDLE. Second command accepted the cycle after done; the first command's rd_last is unaffected.

Source files
------------

// File: rtl/buffer_pool_seq.sv
// Sequencer for the X_MESH x X_MAC dual-port bank array.
// LOAD streams scalar words round-robin across the banks through port A.
// READ sweeps a row range on port B of all banks in lockstep.
// rd_valid lines up with the array's one-cycle registered read latency.
module buffer_pool_seq #(
    parameter int X_MAC      = 4,
    parameter int X_MESH     = 16,
    parameter int ADDR_LEN   = 13,
    parameter int DATA_LEN   = 32,
    parameter int BANK_W     = 6,
    parameter int BUFFER_NUM = X_MAC * X_MESH,
    parameter int LEN_W      = ADDR_LEN + BANK_W
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic                           cmd_op,
    input  logic [ADDR_LEN-1:0]            cmd_base,
    input  logic [LEN_W-1:0]               cmd_len,
    input  logic [DATA_LEN-1:0]            in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [BUFFER_NUM*DATA_LEN-1:0] dina,
    output logic [BUFFER_NUM*ADDR_LEN-1:0] addra,
    output logic [BUFFER_NUM-1:0]          wea,
    output logic [BUFFER_NUM*ADDR_LEN-1:0] addrb,
    output logic                           rd_valid,
    output logic                           rd_last,
    output logic                           busy,
    output logic                           done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_READ  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    localparam logic [BANK_W-1:0]     BANK_LAST = BANK_W'(BUFFER_NUM - 1);
    localparam logic [BANK_W-1:0]     BANK_ONE  = {{(BANK_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0]      LEN_ONE   = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_LEN:0]     ROW_ONE   = {{ADDR_LEN{1'b0}}, 1'b1};
    localparam logic [BUFFER_NUM-1:0] WE_ONE    = {{(BUFFER_NUM-1){1'b0}}, 1'b1};

    state_t                state_r;
    logic [ADDR_LEN-1:0]   base_r;
    logic [LEN_W-1:0]      len_r;
    logic [BANK_W-1:0]     bank_cnt_r;
    // One bit wider than a row address so a READ of 2^ADDR_LEN rows can terminate.
    logic [ADDR_LEN:0]     row_cnt_r;
    logic [LEN_W-1:0]      word_cnt_r;
    logic [ADDR_LEN-1:0]   addrb_r;
    logic                  issue_r;
    logic                  rd_valid_r;
    logic                  rd_last_r;
    logic                  done_r;

    logic                  accept_s;
    logic                  cmd_zero_s;
    logic                  wr_fire_s;
    logic                  rd_row_done_s;
    logic [ADDR_LEN-1:0]   row_addr_s;
    logic [ADDR_LEN-1:0]   wr_row_s;
    logic [BUFFER_NUM-1:0] wea_s;

    // Handshake decode, wrapped row address and one-hot write enable.
    always_comb begin
        accept_s      = cmd_valid && (state_r == S_IDLE);
        // READ only looks at the low ADDR_LEN+1 bits of the length.
        if (cmd_op) begin
            cmd_zero_s = (cmd_len[ADDR_LEN:0] == {(ADDR_LEN+1){1'b0}});
        end else begin
            cmd_zero_s = (cmd_len == {LEN_W{1'b0}});
        end
        wr_fire_s     = (state_r == S_LOAD) && in_valid;
        rd_row_done_s = (row_cnt_r == len_r[ADDR_LEN:0]);
        // Truncation to ADDR_LEN bits gives the silent modulo wrap.
        row_addr_s    = base_r + row_cnt_r[ADDR_LEN-1:0];
        if (state_r == S_LOAD) begin
            wr_row_s = row_addr_s;
        end else begin
            wr_row_s = {ADDR_LEN{1'b0}};
        end
        if (wr_fire_s) begin
            wea_s = WE_ONE << bank_cnt_r;
        end else begin
            wea_s = {BUFFER_NUM{1'b0}};
        end
    end

    assign cmd_ready = (state_r == S_IDLE);
    assign busy      = (state_r != S_IDLE);
    assign in_ready  = (state_r == S_LOAD);
    assign wea       = wea_s;
    assign dina      = {BUFFER_NUM{in_data}};
    assign addra     = {BUFFER_NUM{wr_row_s}};
    assign addrb     = {BUFFER_NUM{addrb_r}};
    assign rd_valid  = rd_valid_r;
    assign rd_last   = rd_last_r;
    assign done      = done_r;

    // Command FSM: counters, read address issue, and the registered strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_IDLE;
            base_r     <= {ADDR_LEN{1'b0}};
            len_r      <= {LEN_W{1'b0}};
            bank_cnt_r <= {BANK_W{1'b0}};
            row_cnt_r  <= {(ADDR_LEN+1){1'b0}};
            word_cnt_r <= {LEN_W{1'b0}};
            addrb_r    <= {ADDR_LEN{1'b0}};
            issue_r    <= 1'b0;
            rd_valid_r <= 1'b0;
            rd_last_r  <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            done_r     <= 1'b0;
            rd_last_r  <= 1'b0;
            issue_r    <= 1'b0;
            // Data from an address issued last cycle is valid now.
            rd_valid_r <= issue_r;
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        if (cmd_zero_s) begin
                            done_r <= 1'b1;
                        end else begin
                            base_r     <= cmd_base;
                            len_r      <= cmd_len;
                            bank_cnt_r <= {BANK_W{1'b0}};
                            row_cnt_r  <= {(ADDR_LEN+1){1'b0}};
                            word_cnt_r <= {LEN_W{1'b0}};
                            state_r    <= cmd_op ? S_READ : S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (wr_fire_s) begin
                        word_cnt_r <= word_cnt_r + LEN_ONE;
                        bank_cnt_r <= bank_cnt_r + BANK_ONE;
                        if (bank_cnt_r == BANK_LAST) begin
                            row_cnt_r <= row_cnt_r + ROW_ONE;
                        end
                        if (word_cnt_r == (len_r - LEN_ONE)) begin
                            state_r <= S_IDLE;
                            done_r  <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    // Once every row is issued, the next cycle carries the last row's data.
                    if (rd_row_done_s) begin
                        state_r   <= S_DRAIN;
                        rd_last_r <= 1'b1;
                        done_r    <= 1'b1;
                    end else begin
                        addrb_r   <= row_addr_s;
                        issue_r   <= 1'b1;
                        row_cnt_r <= row_cnt_r + ROW_ONE;
                    end
                end
                S_DRAIN: begin
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule
